// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 Set-2 key decoder.
//   - prefix / control byte constants
//   - modifier scan codes
//   - prefix FSM state encoding
//   - decoded key event record
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    localparam logic [7:0] LSHIFT = 8'h12;
    localparam logic [7:0] RSHIFT = 8'h59;
    localparam logic [7:0] CAPS   = 8'h58;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } prefix_state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
        logic [7:0] ascii;
    } key_event_t;

    // Keyboard status/error bytes that never belong to a key sequence.
    function automatic logic is_discard(input logic [7:0] b);
        return (b == PS2_ERR0) || (b == PS2_ERR1) || (b == PS2_BAT) ||
               (b == PS2_ACK)  || (b == PS2_ECHO) || (b == PS2_RESEND);
    endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// ps2_ascii_lut: combinational US-layout Set-2 scan code to ASCII map.
// Ports:
//   i_code  [7:0]  un-prefixed scan code
//   i_shift        either shift key held
//   i_caps         caps-lock toggle state
//   o_ascii [7:0]  translated character, 0x00 when the code is unmapped
module ps2_ascii_lut (
    input  logic [7:0] i_code,
    input  logic       i_shift,
    input  logic       i_caps,
    output logic [7:0] o_ascii
);

    logic [7:0] w_lower;    // lowercase letter, 0 if not a letter
    logic [7:0] w_base;     // unshifted glyph for non-letters
    logic [7:0] w_shifted;  // shifted glyph for non-letters

    always_comb begin
        w_lower = 8'h00;
        case (i_code)
            8'h1C: w_lower = 8'h61; 8'h32: w_lower = 8'h62; 8'h21: w_lower = 8'h63;
            8'h23: w_lower = 8'h64; 8'h24: w_lower = 8'h65; 8'h2B: w_lower = 8'h66;
            8'h34: w_lower = 8'h67; 8'h33: w_lower = 8'h68; 8'h43: w_lower = 8'h69;
            8'h3B: w_lower = 8'h6A; 8'h42: w_lower = 8'h6B; 8'h4B: w_lower = 8'h6C;
            8'h3A: w_lower = 8'h6D; 8'h31: w_lower = 8'h6E; 8'h44: w_lower = 8'h6F;
            8'h4D: w_lower = 8'h70; 8'h15: w_lower = 8'h71; 8'h2D: w_lower = 8'h72;
            8'h1B: w_lower = 8'h73; 8'h2C: w_lower = 8'h74; 8'h3C: w_lower = 8'h75;
            8'h2A: w_lower = 8'h76; 8'h1D: w_lower = 8'h77; 8'h22: w_lower = 8'h78;
            8'h35: w_lower = 8'h79; 8'h1A: w_lower = 8'h7A;
            default: w_lower = 8'h00;
        endcase
    end

    // Control keys carry the same value in both columns so shift has no effect.
    always_comb begin
        {w_base, w_shifted} = 16'h0000;
        case (i_code)
            8'h16: {w_base, w_shifted} = 16'h3121; 8'h1E: {w_base, w_shifted} = 16'h3240;
            8'h26: {w_base, w_shifted} = 16'h3323; 8'h25: {w_base, w_shifted} = 16'h3424;
            8'h2E: {w_base, w_shifted} = 16'h3525; 8'h36: {w_base, w_shifted} = 16'h365E;
            8'h3D: {w_base, w_shifted} = 16'h3726; 8'h3E: {w_base, w_shifted} = 16'h382A;
            8'h46: {w_base, w_shifted} = 16'h3928; 8'h45: {w_base, w_shifted} = 16'h3029;
            8'h0E: {w_base, w_shifted} = 16'h607E; 8'h4E: {w_base, w_shifted} = 16'h2D5F;
            8'h55: {w_base, w_shifted} = 16'h3D2B; 8'h54: {w_base, w_shifted} = 16'h5B7B;
            8'h5B: {w_base, w_shifted} = 16'h5D7D; 8'h5D: {w_base, w_shifted} = 16'h5C7C;
            8'h4C: {w_base, w_shifted} = 16'h3B3A; 8'h52: {w_base, w_shifted} = 16'h2722;
            8'h41: {w_base, w_shifted} = 16'h2C3C; 8'h49: {w_base, w_shifted} = 16'h2E3E;
            8'h4A: {w_base, w_shifted} = 16'h2F3F;
            8'h29: {w_base, w_shifted} = 16'h2020; 8'h5A: {w_base, w_shifted} = 16'h0D0D;
            8'h66: {w_base, w_shifted} = 16'h0808; 8'h0D: {w_base, w_shifted} = 16'h0909;
            8'h76: {w_base, w_shifted} = 16'h1B1B;
            default: {w_base, w_shifted} = 16'h0000;
        endcase
    end

    always_comb begin
        if (w_lower != 8'h00)
            o_ascii = (i_shift ^ i_caps) ? (w_lower - 8'h20) : w_lower;
        else
            o_ascii = i_shift ? w_shifted : w_base;
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns validated PS/2 Set-2 bytes into key events.
// Tracks E0/F0 prefixes, shift and caps-lock state, translates printable
// keys to ASCII and queues events in a first-word-fall-through FIFO.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   code_in, code_valid   byte stream from the receive stage
//   ev_valid/ev_ready     FIFO head handshake
//   ev_code/ext/release/ascii  head event fields (0 while empty)
//   shift_active, caps_lock    modifier state
//   overflow              sticky event-dropped flag
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] code_in,
    input  logic       code_valid,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_release,
    output logic [7:0] ev_ascii,
    output logic       shift_active,
    output logic       caps_lock,
    output logic       overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    prefix_state_t r_state, w_state_next;
    logic          w_discard, w_emit, w_ext, w_rel;
    logic          r_lshift, r_rshift, r_caps, r_caps_held;
    logic          w_shift;
    logic [7:0]    w_lut_ascii;
    key_event_t    w_event, w_head;

    key_event_t       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             w_full, w_pop, w_push;

    assign w_discard = code_valid && is_discard(code_in);

    // Prefix FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Prefix FSM: next state
    always_comb begin
        w_state_next = r_state;
        if (w_discard) begin
            w_state_next = ST_IDLE;
        end else if (code_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (code_in == PS2_EXT)      w_state_next = ST_EXT;
                    else if (code_in == PS2_BRK) w_state_next = ST_BRK;
                    else                         w_state_next = ST_IDLE;
                end
                ST_EXT: begin
                    if (code_in == PS2_BRK)      w_state_next = ST_EXT_BRK;
                    else if (code_in == PS2_EXT) w_state_next = ST_EXT;
                    else                         w_state_next = ST_IDLE;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Prefix FSM: outputs (emit strobe and event flags)
    always_comb begin
        w_emit = 1'b0;
        w_ext  = 1'b0;
        w_rel  = 1'b0;
        if (code_valid && !w_discard) begin
            case (r_state)
                ST_IDLE: w_emit = (code_in != PS2_EXT) && (code_in != PS2_BRK);
                ST_EXT: begin
                    w_emit = (code_in != PS2_EXT) && (code_in != PS2_BRK);
                    w_ext  = 1'b1;
                end
                ST_BRK: begin
                    w_emit = 1'b1;
                    w_rel  = 1'b1;
                end
                default: begin
                    w_emit = 1'b1;
                    w_ext  = 1'b1;
                    w_rel  = 1'b1;
                end
            endcase
        end
    end

    // Modifiers: only non-extended codes count (E0 12 is not a shift key).
    // caps_held suppresses retoggling on typematic repeats of the caps key.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lshift    <= 1'b0;
            r_rshift    <= 1'b0;
            r_caps      <= 1'b0;
            r_caps_held <= 1'b0;
        end else if (w_emit && !w_ext) begin
            case (code_in)
                LSHIFT: r_lshift <= !w_rel;
                RSHIFT: r_rshift <= !w_rel;
                CAPS: begin
                    if (w_rel) begin
                        r_caps_held <= 1'b0;
                    end else begin
                        if (!r_caps_held) r_caps <= !r_caps;
                        r_caps_held <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_shift = r_lshift | r_rshift;

    // ASCII uses modifier state from before this byte.
    ps2_ascii_lut u_lut (
        .i_code  (code_in),
        .i_shift (w_shift),
        .i_caps  (r_caps),
        .o_ascii (w_lut_ascii)
    );

    always_comb begin
        w_event.code  = code_in;
        w_event.ext   = w_ext;
        w_event.rel   = w_rel;
        w_event.ascii = (w_ext || w_rel) ? 8'h00 : w_lut_ascii;
    end

    // Event FIFO; a pop frees a slot in the same cycle so push-while-full
    // with a pop is accepted.
    assign w_full = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop  = (r_count != '0) && ev_ready;
    assign w_push = w_emit && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_event;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_emit && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    // Head fields are masked while empty so stale storage never shows.
    assign w_head       = r_mem[r_rd_ptr];
    assign ev_valid     = (r_count != '0);
    assign ev_code      = ev_valid ? w_head.code  : 8'h00;
    assign ev_ext       = ev_valid ? w_head.ext   : 1'b0;
    assign ev_release   = ev_valid ? w_head.rel   : 1'b0;
    assign ev_ascii     = ev_valid ? w_head.ascii : 8'h00;
    assign shift_active = w_shift;
    assign caps_lock    = r_caps;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] code_in = 8'h00;
    logic       code_valid = 1'b0;
    logic       ev_ready = 1'b0;
    logic       ev_valid, ev_ext, ev_release, shift_active, caps_lock, overflow;
    logic [7:0] ev_code, ev_ascii;

    int total = 0;
    int bad = 0;

    ps2_key_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .code_in      (code_in),
        .code_valid   (code_valid),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_code      (ev_code),
        .ev_ext       (ev_ext),
        .ev_release   (ev_release),
        .ev_ascii     (ev_ascii),
        .shift_active (shift_active),
        .caps_lock    (caps_lock),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
        logic [7:0] ascii;
    } ev_t;

    logic [7:0] letter_codes [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                      8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                      8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    logic [7:0] punct_codes [21] = '{8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,
                                     8'h45,8'h0E,8'h4E,8'h55,8'h54,8'h5B,8'h5D,8'h4C,8'h52,
                                     8'h41,8'h49,8'h4A};
    logic [7:0] disc_codes [6] = '{8'h00,8'hFF,8'hAA,8'hFA,8'hEE,8'hFE};
    logic [7:0] mod_codes [3]  = '{8'h12,8'h59,8'h58};
    string letters  = "abcdefghijklmnopqrstuvwxyz";
    logic [7:0] pc_base [21]  = '{8'h31,8'h32,8'h33,8'h34,8'h35,8'h36,8'h37,8'h38,8'h39,
                                  8'h30,8'h60,8'h2D,8'h3D,8'h5B,8'h5D,8'h5C,8'h3B,8'h27,
                                  8'h2C,8'h2E,8'h2F};
    logic [7:0] pc_shift [21] = '{8'h21,8'h40,8'h23,8'h24,8'h25,8'h5E,8'h26,8'h2A,8'h28,
                                  8'h29,8'h7E,8'h5F,8'h2B,8'h7B,8'h7D,8'h7C,8'h3A,8'h22,
                                  8'h3C,8'h3E,8'h3F};

    ev_t  m_q[$];
    logic m_lsh, m_rsh, m_caps, m_held, m_ext, m_brk, m_ovf;

    function automatic logic [7:0] model_ascii(input logic [7:0] c, input logic sh, input logic cp);
        logic [7:0] ch;
        for (int i = 0; i < 26; i++) begin
            if (letter_codes[i] == c) begin
                ch = 8'(letters[i]);
                return (sh ^ cp) ? ch - 8'd32 : ch;
            end
        end
        for (int i = 0; i < 21; i++) begin
            if (punct_codes[i] == c) return sh ? pc_shift[i] : pc_base[i];
        end
        case (c)
            8'h29:   return 8'h20;
            8'h5A:   return 8'h0D;
            8'h66:   return 8'h08;
            8'h0D:   return 8'h09;
            8'h76:   return 8'h1B;
            default: return 8'h00;
        endcase
    endfunction

    function automatic void model_reset();
        m_lsh = 0; m_rsh = 0; m_caps = 0; m_held = 0;
        m_ext = 0; m_brk = 0; m_ovf = 0;
        m_q.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        ev_t e;
        logic ext, rel;
        if (b inside {8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hFE}) begin
            m_ext = 0; m_brk = 0;
            return;
        end
        if (!m_brk && b == 8'hE0) begin m_ext = 1; return; end
        if (!m_brk && b == 8'hF0) begin m_brk = 1; return; end
        ext = m_ext; rel = m_brk;
        m_ext = 0; m_brk = 0;
        e.code  = b;
        e.ext   = ext;
        e.rel   = rel;
        e.ascii = (ext || rel) ? 8'h00 : model_ascii(b, m_lsh | m_rsh, m_caps);
        if (m_q.size() < DEPTH) m_q.push_back(e);
        else                    m_ovf = 1;
        if (!ext) begin
            if (b == 8'h12) m_lsh = !rel;
            if (b == 8'h59) m_rsh = !rel;
            if (b == 8'h58) begin
                if (rel) m_held = 0;
                else begin
                    if (!m_held) m_caps = !m_caps;
                    m_held = 1;
                end
            end
        end
    endfunction

    task automatic cycle(input logic v, input logic [7:0] b, input logic rdy);
        code_valid = v;
        code_in    = b;
        ev_ready   = rdy;
        if (rdy && m_q.size() != 0) m_q.delete(0);
        if (v) model_byte(b);
        @(negedge clk);
        code_valid = 1'b0;
        ev_ready   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; code_valid = 1'b0; ev_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic get_ev(output ev_t got, output logic to);
        to  = 1'b1;
        got = '0;
        for (int i = 0; i < 20; i++) begin
            if (ev_valid) begin to = 1'b0; break; end
            @(negedge clk);
        end
        if (!to) begin
            got = {ev_code, ev_ext, ev_release, ev_ascii};
            $display("event code=%h ext=%b rel=%b ascii=%h", ev_code, ev_ext, ev_release, ev_ascii);
            cycle(1'b0, 8'h00, 1'b1);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({ev_valid, ev_code, ev_ext, ev_release, ev_ascii, shift_active, caps_lock, overflow} !== 23'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {ev_valid, ev_code, ev_ext, ev_release, ev_ascii, shift_active, caps_lock, overflow});
        end
    endtask

    task automatic test_make_break();
        ev_t got; logic to;
        do_reset();
        cycle(1'b1, 8'h1C, 1'b0);
        total++;
        if (ev_valid !== 1'b1) begin bad++; $display("FAIL latency: ev_valid=%b expected 1", ev_valid); end
        cycle(1'b1, 8'hF0, 1'b0);
        cycle(1'b1, 8'h1C, 1'b0);
        get_ev(got, to);
        total++;
        if (to || got !== {8'h1C, 2'b00, 8'h61}) begin bad++; $display("FAIL make_1c: got %h expected %h", got, {8'h1C, 2'b00, 8'h61}); end
        get_ev(got, to);
        total++;
        if (to || got !== {8'h1C, 2'b01, 8'h00}) begin bad++; $display("FAIL break_1c: got %h expected %h", got, {8'h1C, 2'b01, 8'h00}); end
    endtask

    task automatic test_shift();
        ev_t got; logic to;
        do_reset();
        cycle(1'b1, 8'h12, 1'b0);
        total++;
        if (shift_active !== 1'b1) begin bad++; $display("FAIL shift_set: got %b expected 1", shift_active); end
        cycle(1'b1, 8'h1C, 1'b0);
        cycle(1'b1, 8'hF0, 1'b0);
        cycle(1'b1, 8'h12, 1'b0);
        total++;
        if (shift_active !== 1'b0) begin bad++; $display("FAIL shift_clear: got %b expected 0", shift_active); end
        get_ev(got, to);
        total++;
        if (to || got !== {8'h12, 2'b00, 8'h00}) begin bad++; $display("FAIL shift_ev0: got %h expected %h", got, {8'h12, 2'b00, 8'h00}); end
        get_ev(got, to);
        total++;
        if (to || got !== {8'h1C, 2'b00, 8'h41}) begin bad++; $display("FAIL shift_ev1: got %h expected %h", got, {8'h1C, 2'b00, 8'h41}); end
        get_ev(got, to);
        total++;
        if (to || got !== {8'h12, 2'b01, 8'h00}) begin bad++; $display("FAIL shift_ev2: got %h expected %h", got, {8'h12, 2'b01, 8'h00}); end
        total++;
        if (ev_valid !== 1'b0) begin bad++; $display("FAIL shift_count: ev_valid=%b expected 0", ev_valid); end
        cycle(1'b1, 8'hE0, 1'b0);
        cycle(1'b1, 8'h12, 1'b0);
        total++;
        if (shift_active !== 1'b0) begin bad++; $display("FAIL ext_12_shift: got %b expected 0", shift_active); end
        get_ev(got, to);
        total++;
        if (to || got !== {8'h12, 2'b10, 8'h00}) begin bad++; $display("FAIL ext_12_ev: got %h expected %h", got, {8'h12, 2'b10, 8'h00}); end
    endtask

    task automatic test_caps();
        ev_t got; logic to;
        ev_t exp3 [3];
        exp3[0] = {8'h58, 2'b00, 8'h00};
        exp3[1] = {8'h58, 2'b00, 8'h00};
        exp3[2] = {8'h58, 2'b01, 8'h00};
        do_reset();
        cycle(1'b1, 8'h58, 1'b0);
        cycle(1'b1, 8'h58, 1'b0);
        cycle(1'b1, 8'hF0, 1'b0);
        cycle(1'b1, 8'h58, 1'b0);
        total++;
        if (caps_lock !== 1'b1) begin bad++; $display("FAIL caps_once: got %b expected 1", caps_lock); end
        for (int i = 0; i < 3; i++) begin
            get_ev(got, to);
            total++;
            if (to || got !== exp3[i]) begin bad++; $display("FAIL caps_ev%0d: got %h expected %h", i, got, exp3[i]); end
        end
        cycle(1'b1, 8'h1C, 1'b0);
        get_ev(got, to);
        total++;
        if (to || got !== {8'h1C, 2'b00, 8'h41}) begin bad++; $display("FAIL caps_upper: got %h expected %h", got, {8'h1C, 2'b00, 8'h41}); end
        cycle(1'b1, 8'h12, 1'b0);
        cycle(1'b1, 8'h1C, 1'b0);
        get_ev(got, to);
        get_ev(got, to);
        total++;
        if (to || got !== {8'h1C, 2'b00, 8'h61}) begin bad++; $display("FAIL caps_shift_lower: got %h expected %h", got, {8'h1C, 2'b00, 8'h61}); end
        cycle(1'b1, 8'h45, 1'b0);
    endtask

    task automatic test_reset_mid();
        ev_t got; logic to;
        cycle(1'b1, 8'hE0, 1'b0);
        do_reset();
        total++;
        if ({ev_valid, ev_code, ev_ext, ev_release, ev_ascii, shift_active, caps_lock, overflow} !== 23'd0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got %h expected 0",
                     {ev_valid, ev_code, ev_ext, ev_release, ev_ascii, shift_active, caps_lock, overflow});
        end
        cycle(1'b1, 8'h75, 1'b0);
        get_ev(got, to);
        total++;
        if (to || got !== {8'h75, 2'b00, 8'h00}) begin bad++; $display("FAIL reset_mid_ev: got %h expected %h", got, {8'h75, 2'b00, 8'h00}); end
    endtask

    task automatic test_ext();
        ev_t got; logic to;
        ev_t exp4 [4];
        logic [7:0] seq [12] = '{8'hE0,8'h75,8'hE0,8'hF0,8'h75,8'hE0,8'hE0,8'h6B,8'hAA,8'hE0,8'hAA,8'h1C};
        exp4[0] = {8'h75, 2'b10, 8'h00};
        exp4[1] = {8'h75, 2'b11, 8'h00};
        exp4[2] = {8'h6B, 2'b10, 8'h00};
        exp4[3] = {8'h1C, 2'b00, 8'h61};
        do_reset();
        for (int i = 0; i < 12; i++) cycle(1'b1, seq[i], 1'b0);
        for (int i = 0; i < 4; i++) begin
            get_ev(got, to);
            total++;
            if (to || got !== exp4[i]) begin bad++; $display("FAIL ext_ev%0d: got %h expected %h", i, got, exp4[i]); end
        end
        total++;
        if (ev_valid !== 1'b0) begin bad++; $display("FAIL ext_discard: ev_valid=%b expected 0", ev_valid); end
    endtask

    task automatic test_overflow();
        ev_t got; logic to;
        ev_t exp4 [4];
        exp4[0] = {8'h16, 2'b00, 8'h31};
        exp4[1] = {8'h1E, 2'b00, 8'h32};
        exp4[2] = {8'h26, 2'b00, 8'h33};
        exp4[3] = {8'h2E, 2'b00, 8'h35};
        do_reset();
        cycle(1'b1, 8'h15, 1'b0);
        cycle(1'b1, 8'h16, 1'b0);
        cycle(1'b1, 8'h1E, 1'b0);
        cycle(1'b1, 8'h26, 1'b0);
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL full_no_ovf: got %b expected 0", overflow); end
        cycle(1'b1, 8'h25, 1'b0);
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        total++;
        if ({ev_code, ev_ascii} !== 16'h1571) begin bad++; $display("FAIL ovf_head: got %h expected 1571", {ev_code, ev_ascii}); end
        cycle(1'b1, 8'h2E, 1'b1);
        total++;
        if ({overflow, ev_code} !== 9'h116) begin bad++; $display("FAIL push_pop_full: got %h expected 116", {overflow, ev_code}); end
        for (int i = 0; i < 4; i++) begin
            get_ev(got, to);
            total++;
            if (to || got !== exp4[i]) begin bad++; $display("FAIL ovf_drain%0d: got %h expected %h", i, got, exp4[i]); end
        end
        total++;
        if ({ev_valid, overflow} !== 2'b01) begin bad++; $display("FAIL ovf_sticky: got %b expected 01", {ev_valid, overflow}); end
    endtask

    task automatic test_random();
        logic       rdy, v;
        logic [7:0] b;
        int         sel;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rdy = 1'($urandom_range(0, 1));
            v   = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 9);
            case (sel)
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                2:       b = disc_codes[$urandom_range(0, 5)];
                3:       b = mod_codes[$urandom_range(0, 2)];
                4, 5:    b = letter_codes[$urandom_range(0, 25)];
                6, 7:    b = punct_codes[$urandom_range(0, 20)];
                default: b = 8'($urandom);
            endcase
            total++;
            if (ev_valid !== (m_q.size() != 0)) begin
                bad++;
                $display("FAIL rnd_valid[%0d]: got %b expected %b", n, ev_valid, m_q.size() != 0);
            end
            if (rdy && m_q.size() != 0) begin
                total++;
                if ({ev_code, ev_ext, ev_release, ev_ascii} !== m_q[0]) begin
                    bad++;
                    $display("FAIL rnd_head[%0d]: got %h expected %h", n, {ev_code, ev_ext, ev_release, ev_ascii}, m_q[0]);
                end
            end
            cycle(v, b, rdy);
            total++;
            if ({shift_active, caps_lock, overflow} !== {m_lsh | m_rsh, m_caps, m_ovf}) begin
                bad++;
                $display("FAIL rnd_state[%0d]: got %b expected %b", n,
                         {shift_active, caps_lock, overflow}, {m_lsh | m_rsh, m_caps, m_ovf});
            end
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_make_break();
        test_shift();
        test_caps();
        test_reset_mid();
        test_ext();
        test_overflow();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
